// File: rtl/lif_array_if.sv
// Timestep handshake bundle for lif_array: input current vector in, spike/potential vector out.
// Master drives inputs and out_ready; slave returns in_ready and the result.
interface lif_array_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   threshold;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_current;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_spikes;
    logic [N*WIDTH-1:0] potentials;

    modport master (
        output threshold, in_valid, in_current, out_ready,
        input  in_ready, out_valid, out_spikes, potentials
    );

    modport slave (
        input  threshold, in_valid, in_current, out_ready,
        output in_ready, out_valid, out_spikes, potentials
    );
endinterface

// File: rtl/lif_array.sv
// N leaky integrate-and-fire neurons sharing one update engine, one neuron per cycle.
// Latency N cycles accept-to-out_valid; result held until out_ready, no new input accepted meanwhile.
module lif_array #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int RESET_MODE = 0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    lif_array_if.slave lif
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [N-1:0][WIDTH-1:0]  cur_q, cur_d;
    logic [N-1:0][WIDTH-1:0]  v_q, v_d;
    logic [N-1:0][RW-1:0]     r_q, r_d;
    logic [WIDTH-1:0]         thr_q, thr_d;
    logic [N-1:0]             spk_q, spk_d;

    logic [WIDTH-1:0] v_sel, c_sel, v_leak, s, v_new;
    logic [RW-1:0]    r_sel, r_new;
    logic [WIDTH:0]   sum;
    logic             fire;
    logic             last;

    assign last = (idx_q == IDXW'(N - 1));

    // Update engine for the neuron selected by idx_q
    always_comb begin
        v_sel  = v_q[idx_q];
        c_sel  = cur_q[idx_q];
        r_sel  = r_q[idx_q];
        v_leak = v_sel >> LEAK_SHIFT;
        sum    = {1'b0, v_leak} + {1'b0, c_sel};
        s      = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        fire   = 1'b0;
        v_new  = v_sel;
        r_new  = r_sel;
        if (r_sel != '0) begin
            r_new = r_sel - RW'(1);
        end else begin
            fire = (s >= thr_q);
            if (fire) begin
                v_new = (RESET_MODE != 0) ? (s - thr_q) : '0;
                r_new = RW'(REFRAC);
            end else begin
                v_new = s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        thr_d   = thr_q;
        v_d     = v_q;
        r_d     = r_q;
        spk_d   = spk_q;
        case (state_q)
            S_IDLE: begin
                if (lif.in_valid) begin
                    cur_d   = lif.in_current;
                    thr_d   = lif.threshold;
                    spk_d   = '0;
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                v_d[idx_q]   = v_new;
                r_d[idx_q]   = r_new;
                spk_d[idx_q] = fire;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (lif.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            thr_q   <= '0;
            v_q     <= '0;
            r_q     <= '0;
            spk_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            thr_q   <= thr_d;
            v_q     <= v_d;
            r_q     <= r_d;
            spk_q   <= spk_d;
        end
    end

    assign lif.in_ready   = (state_q == S_IDLE) && !rst_i;
    assign lif.out_valid  = (state_q == S_DONE);
    assign lif.out_spikes = spk_q;
    assign lif.potentials = v_q;
endmodule

// File: tb/tb_lif_array.sv
// Directed bench: dut_a uses zero-on-spike reset, dut_b subtract-threshold; both see identical stimulus.
module tb_lif_array;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lif_array_if #(.N(N), .WIDTH(8)) ifa ();
    lif_array_if #(.N(N), .WIDTH(8)) ifb ();

    lif_array #(.N(N), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2), .RESET_MODE(0))
        dut_a (.clk_i(clk), .rst_i(rst), .lif(ifa));
    lif_array #(.N(N), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2), .RESET_MODE(1))
        dut_b (.clk_i(clk), .rst_i(rst), .lif(ifb));

    typedef struct {
        logic        rst_before;
        logic [7:0]  thr;
        logic [31:0] cur;
        logic [3:0]  spk_a;
        logic [31:0] pot_a;
        logic [3:0]  spk_b;
        logic [31:0] pot_b;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] rep(input logic [7:0] x);
        return {4{x}};
    endfunction

    task automatic add(input logic rb, input logic [7:0] thr, input logic [31:0] cur,
                       input logic [3:0] sa, input logic [31:0] pa,
                       input logic [3:0] sb, input logic [31:0] pb, input string nm);
        vec_t v;
        v.rst_before = rb; v.thr = thr; v.cur = cur;
        v.spk_a = sa; v.pot_a = pa; v.spk_b = sb; v.pot_b = pb; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] thr, input logic [31:0] cur, input logic vld);
        ifa.threshold = thr; ifa.in_current = cur; ifa.in_valid = vld;
        ifb.threshold = thr; ifb.in_current = cur; ifb.in_valid = vld;
    endtask

    task automatic set_ordy(input logic r);
        ifa.out_ready = r;
        ifb.out_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(8'h00, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_low", ifa.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy_high", ifa.in_ready, 1'b1);
    endtask

    // Accept one timestep and return the number of edges until out_valid is seen.
    task automatic do_step(input logic [7:0] thr, input logic [31:0] cur, output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!ifa.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", ifa.in_ready, 1'b1);
        drive(thr, cur, 1'b1);
        @(posedge clk); #1;
        drive(8'h00, 32'h0, 1'b0);
        lat = 0;
        while (!ifa.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        add(1, 200, rep(101), 4'h0, rep(101), 4'h0, rep(101), "leak1");
        add(0, 200, rep(101), 4'h0, rep(151), 4'h0, rep(151), "leak2");
        add(0, 200, rep(101), 4'h0, rep(176), 4'h0, rep(176), "leak3");
        add(0, 200, rep(101), 4'h0, rep(189), 4'h0, rep(189), "leak4");
        add(0, 200, rep(101), 4'h0, rep(195), 4'h0, rep(195), "leak5");
        add(0, 200, rep(101), 4'h0, rep(198), 4'h0, rep(198), "leak6");
        add(0, 200, rep(101), 4'hF, 32'h0,    4'hF, 32'h0,    "fire7");
        add(1, 200, rep(100), 4'h0, rep(100), 4'h0, rep(100), "settle1");
        add(0, 200, rep(100), 4'h0, rep(150), 4'h0, rep(150), "settle2");
        add(0, 200, rep(100), 4'h0, rep(175), 4'h0, rep(175), "settle3");
        add(0, 200, rep(100), 4'h0, rep(187), 4'h0, rep(187), "settle4");
        add(0, 200, rep(100), 4'h0, rep(193), 4'h0, rep(193), "settle5");
        add(0, 200, rep(100), 4'h0, rep(196), 4'h0, rep(196), "settle6");
        add(0, 200, rep(100), 4'h0, rep(198), 4'h0, rep(198), "settle7");
        add(0, 200, rep(100), 4'h0, rep(199), 4'h0, rep(199), "settle8");
        add(0, 200, rep(100), 4'h0, rep(199), 4'h0, rep(199), "settle9");
        add(1, 250, 32'h0000_00C8, 4'h0, 32'h0000_00C8, 4'h0, 32'h0000_00C8, "sat1");
        add(0, 250, 32'h0000_00C8, 4'h1, 32'h0,         4'h1, 32'h0000_0005, "sat2");
        add(1, 50,  32'h0000_003C, 4'h1, 32'h0, 4'h1, 32'h0000_000A, "refr1");
        add(0, 50,  32'h0000_003C, 4'h0, 32'h0, 4'h0, 32'h0000_000A, "refr2");
        add(0, 50,  32'h0000_003C, 4'h0, 32'h0, 4'h0, 32'h0000_000A, "refr3");
        add(0, 50,  32'h0000_003C, 4'h1, 32'h0, 4'h1, 32'h0000_000F, "refr4");
        add(1, 250, 32'h00FF_0000, 4'b0100, 32'h0, 4'b0100, 32'h0005_0000, "arm2");
        add(0, 0,   rep(10),       4'b1011, 32'h0, 4'b1011, 32'h0A05_0A0A, "thr0");

        drive(8'h00, 32'h0, 1'b0);
        set_ordy(1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_pot", ifa.potentials, 32'h0);
        chk("init_spk", ifa.out_spikes, 4'h0);
        chk("init_vld", ifa.out_valid, 1'b0);
        chk("init_rdy", ifa.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("init_rdy_rel", ifa.in_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            do_step(vecs[i].thr, vecs[i].cur, lat);
            chk({vecs[i].name, "_lat"},   lat, N);
            chk({vecs[i].name, "_spk_a"}, ifa.out_spikes, vecs[i].spk_a);
            chk({vecs[i].name, "_pot_a"}, ifa.potentials, vecs[i].pot_a);
            chk({vecs[i].name, "_vld_b"}, ifb.out_valid, 1'b1);
            chk({vecs[i].name, "_spk_b"}, ifb.out_spikes, vecs[i].spk_b);
            chk({vecs[i].name, "_pot_b"}, ifb.potentials, vecs[i].pot_b);
        end

        // Backpressure: result held, in_valid ignored while DONE
        do_reset();
        set_ordy(1'b0);
        do_step(200, rep(101), lat);
        chk("bp_lat", lat, N);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld", ifa.out_valid, 1'b1);
            chk("bp_rdy", ifa.in_ready, 1'b0);
            chk("bp_pot", ifa.potentials, rep(101));
            chk("bp_spk", ifa.out_spikes, 4'h0);
            drive(8'd10, rep(7), (k % 2) == 0);
        end
        @(negedge clk);
        drive(8'h00, 32'h0, 1'b0);
        set_ordy(1'b1);
        @(posedge clk); #1;
        chk("hs_rdy", ifa.in_ready, 1'b1);
        chk("hs_vld", ifa.out_valid, 1'b0);
        chk("hs_pot", ifa.potentials, rep(101));

        // Reset during the second update cycle
        @(negedge clk);
        drive(200, rep(101), 1'b1);
        @(posedge clk); #1;
        drive(8'h00, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("upd0_pot", ifa.potentials, 32'h6565_6597);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_pot", ifa.potentials, 32'h0);
        chk("mr_vld", ifa.out_valid, 1'b0);
        chk("mr_rdy_low", ifa.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_rdy", ifa.in_ready, 1'b1);
        chk("mr_pot_rel", ifa.potentials, 32'h0);
        do_step(200, rep(101), lat);
        chk("mr_next_lat", lat, N);
        chk("mr_next_pot", ifa.potentials, rep(101));
        chk("mr_next_spk", ifa.out_spikes, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
